// File: rtl/pi_sequencer.sv
// pi_sequencer: start-up, ramp, watchdog and coefficient sequencing for one PI loop.
// Define PI_SEQ_RAMP_EN to enable rate-limited setpoint ramping (RAMP state).
module pi_sequencer #(
  parameter int inputBitSize      = 27,
  parameter int coeffBitSize      = 27,
  parameter int RESET_HOLD_CYCLES = 4,
  parameter int TIMEOUT_BITS      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic [inputBitSize-1:0] start_setpoint,
  input  logic [inputBitSize-1:0] target_setpoint,
  input  logic [inputBitSize-1:0] ramp_step,
  input  logic [TIMEOUT_BITS-1:0] timeout_cycles,
  input  logic [coeffBitSize-1:0] coeff_kp_new,
  input  logic [coeffBitSize-1:0] coeff_ti_new,
  input  logic                    coeff_load,
  input  logic                    sample_valid,
  input  logic                    pi_output_valid,
  input  logic                    pi_saturated,
  output logic                    pi_reset_pi,
  output logic                    pi_enable_pi,
  output logic                    pi_limiting,
  output logic [inputBitSize-1:0] pi_setpoint,
  output logic [coeffBitSize-1:0] pi_kp_coefficient,
  output logic [coeffBitSize-1:0] pi_ti_coefficient,
  output logic [2:0]              state,
  output logic                    busy,
  output logic                    ramp_done,
  output logic                    coeff_pending,
  output logic                    fault
);

  localparam int N  = inputBitSize;
  localparam int C  = coeffBitSize;
  localparam int TB = TIMEOUT_BITS;
  localparam int HW = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_WAIT  = 3'd2,
    S_RAMP  = 3'd3,
    S_HOLD  = 3'd4,
    S_FAULT = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TB-1:0] wd_q, wd_d;
  logic [N-1:0]  sp_q, sp_d;
  logic [C-1:0]  kp_q, kp_d;
  logic [C-1:0]  ti_q, ti_d;
  logic [C-1:0]  kp_sh_q, kp_sh_d;
  logic [C-1:0]  ti_sh_q, ti_sh_d;
  logic          pend_q, pend_d;
  logic          rst_pi_q, rst_pi_d;
  logic          en_q, en_d;
  logic          lim_q, lim_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;

  logic          wd_trip;
  logic [TB-1:0] wd_inc;
  logic          apply_now;

  assign wd_trip = (timeout_cycles != '0) && (wd_q >= timeout_cycles);
  assign wd_inc  = (wd_q == '1) ? wd_q : wd_q + TB'(1);

`ifdef PI_SEQ_RAMP_EN
  // Ramp maths one bit wider than the setpoint so the difference cannot wrap.
  logic [N:0]   sp_x, tg_x, st_x, diff, mag;
  logic [N-1:0] ramp_nxt;
  logic         ramp_hit;

  assign sp_x     = {sp_q[N-1], sp_q};
  assign tg_x     = {target_setpoint[N-1], target_setpoint};
  assign st_x     = {1'b0, ramp_step};
  assign diff     = tg_x - sp_x;
  assign mag      = diff[N] ? ((N+1)'(0) - diff) : diff;
  assign ramp_hit = (ramp_step == '0) || (mag <= st_x);
  assign ramp_nxt = N'(diff[N] ? (sp_x - st_x) : (sp_x + st_x));
`else
  logic unused_ramp;
  assign unused_ramp = ^{start_setpoint, ramp_step};
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    wd_d    = '0;
    sp_d    = sp_q;

    unique case (state_q)
      S_IDLE: begin
        hold_d = '0;
        if (start && !stop) begin
          state_d = S_CLEAR;
`ifdef PI_SEQ_RAMP_EN
          sp_d = start_setpoint;
`endif
        end
      end
      S_CLEAR: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_WAIT;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_WAIT: begin
        wd_d = wd_inc;
        if (wd_trip) begin
          state_d = S_FAULT;
        end else if (pi_output_valid) begin
          wd_d = '0;
`ifdef PI_SEQ_RAMP_EN
          state_d = S_RAMP;
`else
          state_d = S_HOLD;
          sp_d    = target_setpoint;
`endif
        end
      end
      S_RAMP: begin
        wd_d = pi_output_valid ? '0 : wd_inc;
        if (wd_trip) begin
          state_d = S_FAULT;
        end
`ifdef PI_SEQ_RAMP_EN
        else if (sample_valid) begin
          if (ramp_hit) begin
            sp_d    = target_setpoint;
            state_d = S_HOLD;
          end else begin
            sp_d = ramp_nxt;
          end
        end
`endif
      end
      S_HOLD: begin
        wd_d = pi_output_valid ? '0 : wd_inc;
        if (wd_trip) begin
          state_d = S_FAULT;
        end
`ifdef PI_SEQ_RAMP_EN
        else if (target_setpoint != sp_q) begin
          state_d = S_RAMP;
        end
`else
        else if (sample_valid) begin
          sp_d = target_setpoint;
        end
`endif
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      hold_d  = '0;
      wd_d    = '0;
    end
  end

  // Shadow coefficients reach the PI block only at a sample boundary while running.
  assign apply_now = (state_q inside {S_IDLE, S_CLEAR, S_FAULT}) || sample_valid;

  always_comb begin
    kp_sh_d = kp_sh_q;
    ti_sh_d = ti_sh_q;
    kp_d    = kp_q;
    ti_d    = ti_q;
    pend_d  = pend_q;
    if (coeff_load) begin
      kp_sh_d = coeff_kp_new;
      ti_sh_d = coeff_ti_new;
      pend_d  = 1'b1;
    end else if (pend_q && apply_now) begin
      kp_d   = kp_sh_q;
      ti_d   = ti_sh_q;
      pend_d = 1'b0;
    end
  end

  always_comb begin
    rst_pi_d = state_d inside {S_IDLE, S_CLEAR, S_FAULT};
    en_d     = state_d inside {S_WAIT, S_RAMP, S_HOLD};
    lim_d    = pi_saturated && (state_d inside {S_RAMP, S_HOLD});
    busy_d   = state_d != S_IDLE;
    done_d   = (state_d == S_HOLD) && (sp_d == target_setpoint);
    fault_d  = state_d == S_FAULT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      hold_q   <= '0;
      wd_q     <= '0;
      sp_q     <= '0;
      kp_q     <= '0;
      ti_q     <= '0;
      kp_sh_q  <= '0;
      ti_sh_q  <= '0;
      pend_q   <= 1'b0;
      rst_pi_q <= 1'b1;
      en_q     <= 1'b0;
      lim_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      wd_q     <= wd_d;
      sp_q     <= sp_d;
      kp_q     <= kp_d;
      ti_q     <= ti_d;
      kp_sh_q  <= kp_sh_d;
      ti_sh_q  <= ti_sh_d;
      pend_q   <= pend_d;
      rst_pi_q <= rst_pi_d;
      en_q     <= en_d;
      lim_q    <= lim_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
    end
  end

  assign state             = state_q;
  assign pi_setpoint       = sp_q;
  assign pi_kp_coefficient = kp_q;
  assign pi_ti_coefficient = ti_q;
  assign coeff_pending     = pend_q;
  assign pi_reset_pi       = rst_pi_q;
  assign pi_enable_pi      = en_q;
  assign pi_limiting       = lim_q;
  assign busy              = busy_q;
  assign ramp_done         = done_q;
  assign fault             = fault_q;

endmodule

// File: tb/tb_pi_sequencer.sv
// tb_pi_sequencer: directed and randomized checks of pi_sequencer.
// Honours PI_SEQ_RAMP_EN the same way as the design.
module tb_pi_sequencer;
  localparam int N  = 27;
  localparam int C  = 27;
  localparam int H  = 4;
  localparam int TB = 16;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RAMP  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, stop;
  logic [N-1:0]  start_setpoint, target_setpoint, ramp_step;
  logic [TB-1:0] timeout_cycles;
  logic [C-1:0]  coeff_kp_new, coeff_ti_new;
  logic          coeff_load, sample_valid, pi_output_valid, pi_saturated;
  logic          pi_reset_pi, pi_enable_pi, pi_limiting;
  logic [N-1:0]  pi_setpoint;
  logic [C-1:0]  pi_kp_coefficient, pi_ti_coefficient;
  logic [2:0]    state;
  logic          busy, ramp_done, coeff_pending, fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pi_sequencer #(
    .inputBitSize(N), .coeffBitSize(C),
    .RESET_HOLD_CYCLES(H), .TIMEOUT_BITS(TB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .start_setpoint(start_setpoint), .target_setpoint(target_setpoint),
    .ramp_step(ramp_step), .timeout_cycles(timeout_cycles),
    .coeff_kp_new(coeff_kp_new), .coeff_ti_new(coeff_ti_new),
    .coeff_load(coeff_load), .sample_valid(sample_valid),
    .pi_output_valid(pi_output_valid), .pi_saturated(pi_saturated),
    .pi_reset_pi(pi_reset_pi), .pi_enable_pi(pi_enable_pi),
    .pi_limiting(pi_limiting), .pi_setpoint(pi_setpoint),
    .pi_kp_coefficient(pi_kp_coefficient),
    .pi_ti_coefficient(pi_ti_coefficient),
    .state(state), .busy(busy), .ramp_done(ramp_done),
    .coeff_pending(coeff_pending), .fault(fault)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint sext(input logic [N-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic logic [N-1:0] tr(input longint v);
    return v[N-1:0];
  endfunction

  // Next setpoint on a sample: jump if close enough or step==0, else move by step.
  function automatic longint ramp_next(input longint sp, input longint tg,
                                       input logic [N-1:0] st);
    longint d, s, a;
    d = tg - sp;
    s = longint'(st);
    a = (d < 0) ? -d : d;
    if (s == 0 || a <= s) return tg;
    return (d > 0) ? sp + s : sp - s;
  endfunction

  task automatic do_run(input logic [N-1:0] s0, input logic [N-1:0] tg,
                        input logic [N-1:0] st, input int exp_n);
    longint sp;
    int n;
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("run_idle", state, S_IDLE);
    start_setpoint  = s0;
    target_setpoint = tg;
    ramp_step       = st;
    pi_output_valid = 1'b0;
    sample_valid    = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (H) step();
    chk("run_wait", state, S_WAIT);
    pi_output_valid = 1'b1;
    sample_valid    = 1'b1;
    step();
`ifdef PI_SEQ_RAMP_EN
    chk("run_sp_origin", pi_setpoint, s0);
    chk("run_ramp_entry", state, S_RAMP);
    sp = sext(s0);
    n  = 0;
    while (state == S_RAMP && n < 300) begin
      sp = ramp_next(sp, sext(tg), st);
      step();
      n++;
      chk("run_sp", pi_setpoint, tr(sp));
    end
    chk("run_nsamples", n, exp_n);
`else
    n  = exp_n;
    sp = sext(tg);
    chk("run_sp", pi_setpoint, tr(sp));
`endif
    chk("run_hold", state, S_HOLD);
    chk("run_done", ramp_done, 1);
    chk("run_target", pi_setpoint, tg);
    sample_valid = 1'b0;
  endtask

  longint spm;
  logic [2:0] ms;
  logic [C-1:0] kpm, tim, shk, sht;
  logic pend;
  logic [N-1:0] tg0;

  initial begin
    reset = 1'b1; start = 0; stop = 0; coeff_load = 0; sample_valid = 0;
    pi_output_valid = 0; pi_saturated = 0; timeout_cycles = '0;
    start_setpoint = '0; target_setpoint = '0; ramp_step = '0;
    coeff_kp_new = '0; coeff_ti_new = '0;
    step();
    step();
    chk("rst_state", state, S_IDLE);
    chk("rst_reset_pi", pi_reset_pi, 1);
    chk("rst_enable", pi_enable_pi, 0);
    chk("rst_limiting", pi_limiting, 0);
    chk("rst_setpoint", pi_setpoint, 0);
    chk("rst_kp", pi_kp_coefficient, 0);
    chk("rst_ti", pi_ti_coefficient, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", ramp_done, 0);
    chk("rst_pending", coeff_pending, 0);
    chk("rst_fault", fault, 0);
    reset = 1'b0;

    // coefficient load while idle
    coeff_kp_new = 27'h0AAAAAA;
    coeff_ti_new = 27'h0123456;
    coeff_load = 1'b1;
    step();
    coeff_load = 1'b0;
    chk("idle_kp_before", pi_kp_coefficient, 0);
    chk("idle_pending", coeff_pending, 1);
    step();
    chk("idle_kp_applied", pi_kp_coefficient, 27'h0AAAAAA);
    chk("idle_ti_applied", pi_ti_coefficient, 27'h0123456);
    chk("idle_pending_clr", coeff_pending, 0);

    // start timing
    start = 1'b1;
    step();
    start = 1'b0;
    chk("clr_state_n1", state, S_CLEAR);
    chk("clr_reset_pi_n1", pi_reset_pi, 1);
    chk("clr_enable_n1", pi_enable_pi, 0);
    chk("clr_busy_n1", busy, 1);
    for (int i = 2; i <= H; i++) begin
      step();
      chk("clr_state", state, S_CLEAR);
      chk("clr_reset_pi", pi_reset_pi, 1);
    end
    step();
    chk("wait_state", state, S_WAIT);
    chk("wait_enable", pi_enable_pi, 1);
    chk("wait_reset_pi", pi_reset_pi, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_ignored_busy", state, S_WAIT);

    // ramps: up, down, clamped step, zero step
    do_run(27'h0, 27'h0100000, 27'h0040000, 4);
    do_run(27'h0, 27'h7F00000, 27'h0040000, 4);
    do_run(27'h0, 27'h0100000, 27'h0070000, 3);
    do_run(27'h5, 27'h0000123, 27'h0, 1);

    // coefficient load while holding
    coeff_kp_new = 27'h2000000;
    coeff_ti_new = 27'h0000777;
    coeff_load = 1'b1;
    step();
    coeff_load = 1'b0;
    chk("hold_kp_unchanged", pi_kp_coefficient, 27'h0AAAAAA);
    chk("hold_pending", coeff_pending, 1);
    step();
    step();
    chk("hold_kp_still", pi_kp_coefficient, 27'h0AAAAAA);
    chk("hold_pending_still", coeff_pending, 1);
    sample_valid = 1'b1;
    step();
    chk("hold_kp_applied", pi_kp_coefficient, 27'h2000000);
    chk("hold_ti_applied", pi_ti_coefficient, 27'h0000777);
    chk("hold_pending_clr", coeff_pending, 0);
    coeff_kp_new = 27'h0000123;
    coeff_load = 1'b1;
    step();
    coeff_load = 1'b0;
    chk("same_cycle_kp", pi_kp_coefficient, 27'h2000000);
    chk("same_cycle_pending", coeff_pending, 1);
    step();
    chk("same_cycle_next_kp", pi_kp_coefficient, 27'h0000123);
    sample_valid = 1'b0;

    // limiting and watchdog while holding
    pi_saturated = 1'b1;
    step();
    chk("hold_limiting", pi_limiting, 1);
    timeout_cycles = 16'd3;
    pi_output_valid = 1'b0;
    repeat (3) step();
    chk("hold_wd_not_yet", state, S_HOLD);
    step();
    chk("hold_wd_fault", state, S_FAULT);
    chk("fault_flag", fault, 1);
    chk("fault_reset_pi", pi_reset_pi, 1);
    chk("fault_limiting", pi_limiting, 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("fault_stop_idle", state, S_IDLE);
    chk("fault_cleared", fault, 0);
    chk("idle_limiting", pi_limiting, 0);

    // stop and start together while running
    timeout_cycles = '0;
    start_setpoint = '0;
    target_setpoint = 27'h0100000;
    ramp_step = 27'h10;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (H) step();
    pi_output_valid = 1'b1;
    step();
`ifdef PI_SEQ_RAMP_EN
    chk("run_state_ramp", state, S_RAMP);
`else
    chk("run_state_hold", state, S_HOLD);
`endif
    chk("run_limiting", pi_limiting, 1);
    stop = 1'b1;
    start = 1'b1;
    step();
    stop = 1'b0;
    start = 1'b0;
    chk("stop_wins_state", state, S_IDLE);
    chk("stop_wins_busy", busy, 0);
    chk("stop_wins_limiting", pi_limiting, 0);
    step();
    chk("stop_wins_stays", state, S_IDLE);

    // watchdog in WAIT_VALID
    pi_saturated = 1'b0;
    pi_output_valid = 1'b0;
    timeout_cycles = 16'd10;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (H) step();
    chk("wd_entry", state, S_WAIT);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("wd_waiting", state, S_WAIT);
    end
    step();
    chk("wd_fault", state, S_FAULT);
    chk("wd_fault_flag", fault, 1);
    chk("wd_reset_pi", pi_reset_pi, 1);
    chk("wd_enable", pi_enable_pi, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("wd_start_ignored", state, S_FAULT);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("wd_stop_idle", state, S_IDLE);
    chk("wd_stop_fault", fault, 0);

    // reset in the middle of a run
    timeout_cycles = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("midrst_state", state, S_IDLE);
    chk("midrst_kp", pi_kp_coefficient, 0);
    chk("midrst_sp", pi_setpoint, 0);
    chk("midrst_reset_pi", pi_reset_pi, 1);
    chk("midrst_busy", busy, 0);
    reset = 1'b0;

    // randomized run against the reference model
    tg0 = N'($urandom);
    do_run(27'h0, tg0, 27'h0, 1);
    ms = S_HOLD; spm = sext(tg0);
    kpm = '0; tim = '0; shk = '0; sht = '0; pend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(11) == 0) begin
        target_setpoint = N'($urandom);
        ramp_step = ($urandom_range(7) == 0) ? '0 :
                    N'($urandom_range(1 << 25, 1 << 20));
      end
      sample_valid = 1'($urandom_range(1));
      coeff_load   = ($urandom_range(7) == 0);
      pi_saturated = 1'($urandom_range(1));
      if (coeff_load) begin
        coeff_kp_new = C'($urandom);
        coeff_ti_new = C'($urandom);
      end
      step();
      if (coeff_load) begin
        shk = coeff_kp_new; sht = coeff_ti_new; pend = 1'b1;
      end else if (pend && sample_valid) begin
        kpm = shk; tim = sht; pend = 1'b0;
      end
`ifdef PI_SEQ_RAMP_EN
      if (ms == S_HOLD) begin
        if (tr(spm) != target_setpoint) ms = S_RAMP;
      end else if (sample_valid) begin
        spm = ramp_next(spm, sext(target_setpoint), ramp_step);
        if (spm == sext(target_setpoint)) ms = S_HOLD;
      end
`else
      if (sample_valid) spm = sext(target_setpoint);
`endif
      chk("rnd_state", state, ms);
      chk("rnd_sp", pi_setpoint, tr(spm));
      chk("rnd_done", ramp_done,
          (ms == S_HOLD) && (tr(spm) == target_setpoint));
      chk("rnd_kp", pi_kp_coefficient, kpm);
      chk("rnd_ti", pi_ti_coefficient, tim);
      chk("rnd_pending", coeff_pending, pend);
      chk("rnd_limiting", pi_limiting, pi_saturated);
    end
    coeff_load = 1'b0;
    sample_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
